cdb_arbiter: RTL
================

# cdb_arbiter

Parametrised common-data-bus arbiter for the Tomasulo back end. It collects results from `NUM_FU` functional units (ALU, branch ALU, multiplier, divider, memory) and grants one per cycle onto the CDB that feeds the ROB and all reservation stations. It generalises the fixed two-unit ALU-over-MUL priority chain to N channels with round-robin fairness, double-grant protection and flush support.

## Interface
- `NUM_FU`, default 4: number of functional-unit result channels (≥2).
- `DATA_WIDTH`, default 32: result value / dest width.
- `ROB_IX_WIDTH`, default 3: ROB index width (ROB SIZE 8).

- `clk_in` input 1: system clock; the block uses this one clock only.
- `rst_in` input 1: synchronous, active-high reset.
- `flush_in` input 1: squash pending broadcast (mispredict).
- `fu_valid_in` input [NUM_FU]: channel i has a result; held high until read.
- `fu_rob_ix_in` input [NUM_FU][ROB_IX_WIDTH]: ROB index per channel.
- `fu_value_in` input [NUM_FU][DATA_WIDTH]: result per channel.
- `fu_dest_in` input [NUM_FU][DATA_WIDTH]: store/dest address per channel (0 when unused).
- `fu_read_out` output [NUM_FU]: one-hot, one-cycle read pulse to the granted FU.
- `cdb_valid_out` output 1: CDB broadcast valid.
- `cdb_rob_ix_out` output ROB_IX_WIDTH: broadcast ROB index.
- `cdb_value_out` output DATA_WIDTH: broadcast value.
- `cdb_dest_out` output DATA_WIDTH: broadcast dest.

## Operation
- Per cycle, eligible set E = `fu_valid_in & ~holdoff`.
- Round-robin: `rr_ptr` (clog2(NUM_FU) bits) names the highest-priority channel; search rr_ptr, rr_ptr+1, … wrapping modulo NUM_FU; first member of E wins.
- On grant of channel g: register g's rob_ix/value/dest onto the CDB outputs, `cdb_valid_out`<=1, `fu_read_out`<=one-hot(g), `holdoff`<=one-hot(g), `rr_ptr`<=(g+1) mod NUM_FU (wraps NUM_FU-1→0).
- E empty: `cdb_valid_out`<=0, `fu_read_out`<=0, `holdoff`<=0, `rr_ptr` unchanged, data outputs hold last value.
- Holdoff: an FU samples its read pulse one cycle after the grant and drops valid the following edge, so the granted channel is masked for exactly the next cycle; a different channel can be granted in that cycle.
- `flush_in` high: no grant; `cdb_valid_out`, `fu_read_out`, `holdoff` <=0; `rr_ptr` unchanged. Results already on the CDB in the flush cycle stay visible for that cycle only.
- Simultaneous valids: exactly one grant per cycle; losers stay pending, no data loss.
- All NUM_FU valid continuously: grants rotate 0,1,…,NUM_FU-1,0,…; starvation bound NUM_FU cycles.

## Timing
- Reset values: `cdb_valid_out`=0, `cdb_rob_ix_out`=0, `cdb_value_out`=0, `cdb_dest_out`=0, `fu_read_out`=0, `holdoff`=0, `rr_ptr`=0.
- Latency: `fu_valid_in[i]` high at edge t (eligible, winning) → `cdb_valid_out` and `fu_read_out[i]` high in cycle t+1, for one cycle.
- Arbitration is combinational on inputs sampled at the edge; all outputs are registered, no combinational input→output path.
- Throughput: one broadcast per cycle when ≥2 channels are pending; a single channel alone can broadcast at most every other cycle (holdoff).
- Reset mid-operation: all outputs to reset values at the next edge; pending FU valids re-arbitrate from rr_ptr=0 after reset deasserts.

## Configuration
- `CDB_FIXED_PRIORITY_EN` defined: rr_ptr is removed; the lowest-index eligible channel always wins (channel 0 = ALU highest). Holdoff and flush are unchanged.
- Undefined (default): round-robin as above.

## Test plan
- Reset: assert `rst_in` 2 cycles with all valids high → all outputs 0, and no grant until the cycle after deassert; the first grant is channel 0.
- Single channel: `fu_valid_in`=4'b0100 held, rob_ix=5, value=0xDEADBEEF → `cdb_valid_out` pulses with rob_ix 5/0xDEADBEEF, `fu_read_out`=4'b0100; next cycle no grant (holdoff); the FU model drops valid → no further broadcast.
- Contention: all four valid, each FU model drops valid after its read → grants 0,1,2,3 on consecutive cycles, values matching each channel, no duplicate ROB index.
- Wrap and fairness: rr_ptr=3, channels 0 and 3 valid continuously → grants 3,0,3,0…; with `CDB_FIXED_PRIORITY_EN` → grants 0,3,0,3 (0 wins each non-holdoff cycle).
- Flush: channel 1 valid, `flush_in` high in the same cycle → no broadcast and no read pulse next cycle; deassert flush → channel 1 granted the following cycle.
- Parametrisation: NUM_FU=5, ROB_IX_WIDTH=4, all valid → rotation 0-4 then wraps to 0; rob_ix 15 broadcasts intact.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one registered grant per cycle among NUM_FU result channels.
// Define CDB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of round-robin.
module cdb_arbiter #(
  parameter int NUM_FU       = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_IX_WIDTH = 3
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     flush_in,
  input  logic [NUM_FU-1:0]                        fu_valid_in,
  input  logic [NUM_FU-1:0][ROB_IX_WIDTH-1:0]      fu_rob_ix_in,
  input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]        fu_value_in,
  input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]        fu_dest_in,
  output logic [NUM_FU-1:0]                        fu_read_out,
  output logic                                     cdb_valid_out,
  output logic [ROB_IX_WIDTH-1:0]                  cdb_rob_ix_out,
  output logic [DATA_WIDTH-1:0]                    cdb_value_out,
  output logic [DATA_WIDTH-1:0]                    cdb_dest_out
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] holdoff;
  logic [NUM_FU-1:0] eligible;
  logic [PTR_W-1:0]  scan_ix;
  logic [PTR_W-1:0]  grant_ix;
  logic              grant_found;
  logic [NUM_FU-1:0] grant_onehot;

`ifndef CDB_FIXED_PRIORITY_EN
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_nxt;
`endif

  // Channel granted last cycle is still asserting valid until its FU sees the read pulse.
  assign eligible = fu_valid_in & ~holdoff;

  always_comb begin
    scan_ix     = '0;
    grant_ix    = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
`ifdef CDB_FIXED_PRIORITY_EN
      scan_ix = PTR_W'(k);
`else
      scan_ix = PTR_W'((int'(rr_ptr) + k) % NUM_FU);
`endif
      if (!grant_found && eligible[scan_ix]) begin
        grant_found = 1'b1;
        grant_ix    = scan_ix;
      end
    end
  end

  assign grant_onehot = {{(NUM_FU-1){1'b0}}, 1'b1} << grant_ix;

`ifndef CDB_FIXED_PRIORITY_EN
  assign rr_ptr_nxt = (grant_ix == PTR_W'(NUM_FU - 1)) ? '0 : grant_ix + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr <= '0;
    end else if (!flush_in && grant_found) begin
      rr_ptr <= rr_ptr_nxt;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid_out  <= 1'b0;
      cdb_rob_ix_out <= '0;
      cdb_value_out  <= '0;
      cdb_dest_out   <= '0;
      fu_read_out    <= '0;
      holdoff        <= '0;
    end else if (flush_in || !grant_found) begin
      // Data outputs keep their last value; only the qualifiers drop.
      cdb_valid_out <= 1'b0;
      fu_read_out   <= '0;
      holdoff       <= '0;
    end else begin
      cdb_valid_out  <= 1'b1;
      cdb_rob_ix_out <= fu_rob_ix_in[grant_ix];
      cdb_value_out  <= fu_value_in[grant_ix];
      cdb_dest_out   <= fu_dest_in[grant_ix];
      fu_read_out    <= grant_onehot;
      holdoff        <= grant_onehot;
    end
  end

endmodule
